// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, halt freeze
// and an optional skid entry that makes in_ready a pure register output.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 72,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              valid_q, skid_valid;
  logic [CTRL_W-1:0] ctrl_q, skid_ctrl;
  logic [DATA_W-1:0] data_q, skid_data;
  logic              push, pop, main_load;

  assign out_valid = valid_q & ~halted;
  // ctrl_q is already cleared when empty; the gate also hides it during halt
  assign out_ctrl  = out_valid ? ctrl_q : '0;
  assign out_data  = data_q;
  assign occupancy = 2'(valid_q) + 2'(skid_valid);

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign main_load = pop | ~valid_q;

  // Main entry: refills from skid when it holds something, else from input
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!halted && main_load) begin
      if (skid_valid) begin
        valid_q <= 1'b1;
        ctrl_q  <= skid_ctrl;
      end else begin
        valid_q <= push;
        ctrl_q  <= push ? in_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!halted && main_load)
      data_q <= skid_valid ? skid_data : in_data;
  end

  generate
    if (SKID) begin : g_skid
      assign in_ready = ~skid_valid & ~halted;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (!halted) begin
          if (skid_valid && main_load) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
          end else if (valid_q && !out_ready && push) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!halted && valid_q && !out_ready && push)
          skid_data <= in_data;
      end
    end else begin : g_noskid
      assign in_ready   = (~valid_q | out_ready) & ~halted;
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector table for the skid variant plus a scoreboarded random run
// on the single-entry variant.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        reset, halted, flush, in_valid, out_ready;
  logic [2:0]  in_ctrl;
  logic [71:0] in_data;
  logic        in_ready, out_valid;
  logic [2:0]  out_ctrl;
  logic [71:0] out_data;
  logic [1:0]  occupancy;

  // SKID=0 instance
  logic        reset0, halted0, flush0, in_valid0, out_ready0;
  logic [2:0]  in_ctrl0;
  logic [71:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [2:0]  out_ctrl0;
  logic [71:0] out_data0;
  logic [1:0]  occupancy0;

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(72), .SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .halted(halted), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(72), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .halted(halted0), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0),
    .out_data(out_data0), .occupancy(occupancy0)
  );

  typedef struct packed {
    logic        rst, fl, hlt, iv;
    logic [2:0]  ic;
    logic [71:0] id;
    logic        ordy;
    logic        ov;
    logic [2:0]  oc;
    logic [71:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   step = 0;

  function automatic logic [71:0] pat(input logic [7:0] b);
    return {b, 56'h0123456789abcd, b};
  endfunction

  function automatic vec_t v(input logic rst, fl, hlt, iv, input logic [2:0] ic,
                             input logic [7:0] id, input logic ordy, input logic ov,
                             input logic [2:0] oc, input logic [7:0] od,
                             input logic [1:0] occ, input logic ir);
    vec_t t;
    t.rst = rst; t.fl = fl; t.hlt = hlt; t.iv = iv; t.ic = ic; t.id = pat(id);
    t.ordy = ordy; t.ov = ov; t.oc = oc; t.od = pat(od); t.occ = occ; t.ir = ir;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [74:0] sb[$];
  logic        h, e_v, e_ov, e_ir;

  initial begin
    //     rst fl hl iv ic    id     rdy | ov oc    od     occ ir
    // back-to-back pushes, out_ready=1
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,1,3'd5,8'h01,1, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,1,3'd5,8'h02,1, 1,3'd5,8'h01,2'd1,1));
    tv.push_back(v(0,0,0,1,3'd5,8'h03,1, 1,3'd5,8'h02,2'd1,1));
    tv.push_back(v(0,0,0,1,3'd5,8'h04,1, 1,3'd5,8'h03,2'd1,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 1,3'd5,8'h04,2'd1,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 0,3'd0,8'h00,2'd0,1));
    // skid fill: A main, B skid, C refused until drained
    tv.push_back(v(0,0,0,1,3'd1,8'h0a,0, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,1,3'd2,8'h0b,0, 1,3'd1,8'h0a,2'd1,1));
    tv.push_back(v(0,0,0,1,3'd3,8'h0c,0, 1,3'd1,8'h0a,2'd2,0));
    tv.push_back(v(0,0,0,1,3'd3,8'h0c,0, 1,3'd1,8'h0a,2'd2,0));
    tv.push_back(v(0,0,0,1,3'd3,8'h0c,1, 1,3'd1,8'h0a,2'd2,0));
    tv.push_back(v(0,0,0,1,3'd3,8'h0c,1, 1,3'd2,8'h0b,2'd1,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 1,3'd3,8'h0c,2'd1,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 0,3'd0,8'h00,2'd0,1));
    // flush a full stage, then flush an accepted push
    tv.push_back(v(0,0,0,1,3'd4,8'h11,0, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,1,3'd6,8'h22,0, 1,3'd4,8'h11,2'd1,1));
    tv.push_back(v(0,1,0,1,3'd7,8'h33,0, 1,3'd4,8'h11,2'd2,0));
    tv.push_back(v(0,1,0,1,3'd7,8'h33,0, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,2'd0,1));
    // halt for 3 cycles, entry reappears unchanged
    tv.push_back(v(0,0,0,1,3'd7,8'h77,1, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,1,1,3'd2,8'h88,1, 0,3'd0,8'h00,2'd1,0));
    tv.push_back(v(0,0,1,1,3'd2,8'h88,1, 0,3'd0,8'h00,2'd1,0));
    tv.push_back(v(0,0,1,1,3'd2,8'h88,1, 0,3'd0,8'h00,2'd1,0));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,0, 1,3'd7,8'h77,2'd1,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 1,3'd7,8'h77,2'd1,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 0,3'd0,8'h00,2'd0,1));
    // flush wins over halt
    tv.push_back(v(0,0,0,1,3'd1,8'h05,0, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,1,1,0,3'd0,8'h00,0, 0,3'd0,8'h00,2'd1,0));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,2'd0,1));
    // reset with a push while full
    tv.push_back(v(0,0,0,1,3'd1,8'h41,0, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,1,3'd2,8'h42,0, 1,3'd1,8'h41,2'd1,1));
    tv.push_back(v(1,0,0,1,3'd3,8'h43,0, 1,3'd1,8'h41,2'd2,0));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,0, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,1,3'd5,8'h55,1, 0,3'd0,8'h00,2'd0,1));
    tv.push_back(v(0,0,0,0,3'd0,8'h00,1, 1,3'd5,8'h55,2'd1,1));

    reset = 1'b1; halted = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    reset0 = 1'b1; halted0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_ctrl0 = '0; in_data0 = '0;
    repeat (2) @(posedge clk);

    foreach (tv[i]) begin
      @(negedge clk);
      step = i;
      reset = tv[i].rst; flush = tv[i].fl; halted = tv[i].hlt; in_valid = tv[i].iv;
      in_ctrl = tv[i].ic; in_data = tv[i].id; out_ready = tv[i].ordy;
      #1;
      cmp("out_valid", 72'(out_valid), 72'(tv[i].ov));
      cmp("out_ctrl",  72'(out_ctrl),  72'(tv[i].oc));
      cmp("occupancy", 72'(occupancy), 72'(tv[i].occ));
      cmp("in_ready",  72'(in_ready),  72'(tv[i].ir));
      if (tv[i].ov) cmp("out_data", out_data, tv[i].od);
    end

    // single-entry variant against a queue model
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      step = 1000 + c;
      reset0 = 1'b0;
      h = ($urandom_range(0, 15) == 0);
      halted0 = h;
      in_valid0 = 1'($urandom_range(0, 1));
      out_ready0 = 1'($urandom_range(0, 1));
      in_ctrl0 = 3'($urandom);
      in_data0 = 72'({$urandom, $urandom, $urandom});
      #1;
      e_v  = (sb.size() != 0);
      e_ov = e_v & ~h;
      e_ir = (~e_v | out_ready0) & ~h;
      cmp("s0_out_valid", 72'(out_valid0), 72'(e_ov));
      cmp("s0_in_ready",  72'(in_ready0),  72'(e_ir));
      cmp("s0_occupancy", 72'(occupancy0), 72'(sb.size()));
      if (e_ov) begin
        cmp("s0_out_ctrl", 72'(out_ctrl0), 72'(sb[0][74:72]));
        cmp("s0_out_data", out_data0, sb[0][71:0]);
      end else begin
        cmp("s0_out_ctrl", 72'(out_ctrl0), 72'd0);
      end
      if (e_ov && out_ready0) sb.pop_front();
      if (in_valid0 && e_ir) sb.push_back({in_ctrl0, in_data0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
